// File: rtl/count_cmd_sequencer.sv
// count_cmd_sequencer: queues {select,length} count commands and
// replays each as a run of En pulses with a stable Slt.
module count_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Cmd_valid,
  output logic                        Cmd_ready,
  input  logic                        Cmd_slt,
  input  logic [LEN_W-1:0]            Cmd_len,
  input  logic                        Hold,
  input  logic                        Flush,
  output logic                        En,
  output logic                        Slt,
  output logic                        Done,
  output logic                        Busy,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  logic             slt_mem [FIFO_DEPTH];
  logic [LEN_W-1:0] len_mem [FIFO_DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             slt_q, slt_d;
  logic             done_q, done_d;

  logic             push;
  logic             pop;
  logic             empty;

  assign empty      = (cnt_q == '0);
  assign Cmd_ready  = !Reset && !Flush &&
                      (cnt_q < CW'(FIFO_DEPTH));
  assign push       = Cmd_valid && Cmd_ready;
  assign Done       = done_q;
  assign Busy       = (state_q == RUN) || !empty;
  assign Fifo_count = cnt_q;

  // Run sequencing, FIFO bookkeeping and the counter-facing outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    rem_d    = rem_q;
    slt_d    = slt_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    En       = (state_q == RUN) && !Hold;
    Slt      = (state_q == RUN) ? slt_q : 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          rem_d = len_mem[rd_ptr_q];
          slt_d = slt_mem[rd_ptr_q];
          if (len_mem[rd_ptr_q] != '0) begin
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (En) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (Flush) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      rem_d    = '0;
      done_d   = 1'b0;
    end
  end

  // Control state, synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      rem_q    <= '0;
      slt_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      rem_q    <= rem_d;
      slt_q    <= slt_d;
      done_q   <= done_d;
    end
  end

  // Command storage; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (push) begin
      slt_mem[wr_ptr_q] <= Cmd_slt;
      len_mem[wr_ptr_q] <= Cmd_len;
    end
  end

endmodule
